pll_reset_seq: RTL and testbench

// - Sequencer at the control end of the system PLL's rst/locked interface: drives the PLL reset and consumes its locked output.
// - Sequence: pulse PLL reset, wait for lock, qualify lock as stable, then release the system reset.
// - On loss of lock: re-asserts system reset and restarts the sequence; retries on lock timeout; flags permanent failure.
// - Runs on the 50 MHz reference clock, never on the PLL output.

---
 rtl/pll_reset_seq_if.sv | 33 +++
 rtl/pll_reset_seq.sv | 154 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pll_reset_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_seq_if
// Brief    : PLL rst/locked handshake plus system reset status bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface pll_reset_seq_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [7:0] lock_loss_count;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_reset,
        output ready,
        output fail,
        output lock_loss_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_reset,
        input  ready,
        input  fail,
        input  lock_loss_count
    );
endinterface
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_seq
// Brief    : Pulses PLL reset, qualifies lock, then releases system reset.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic             refclk,
    input  logic             rst_n,
    pll_reset_seq_if.master  bus
);

    localparam int c_max_a   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_cnt_max = (c_max_a > LOCK_TIMEOUT_CYCLES) ? c_max_a : LOCK_TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_ret_w   = $clog2(MAX_RETRIES + 1);

    localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_ret_w-1:0] c_max_retries  = c_ret_w'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_ret_w-1:0]   r_retries;
    logic [c_ret_w-1:0]   w_retries_nxt;
    logic [c_ret_w-1:0]   w_retries_inc;
    logic                 w_loss;

    logic                 r_locked_m;
    logic                 r_locked_s;
    logic                 r_pll_rst;
    logic                 r_sys_reset;
    logic                 r_ready;
    logic                 r_fail;
    logic [7:0]           r_lock_loss_count;

    // pll_locked comes from the PLL's own domain; only r_locked_s is trusted.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked_m <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_locked_m <= bus.pll_locked;
            r_locked_s <= r_locked_m;
        end
    end

    assign w_retries_inc = r_retries + c_ret_w'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_loss        = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_timeout_last) begin
                    w_retries_nxt = w_retries_inc;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = (w_retries_inc == c_max_retries) ? ST_FAIL : ST_PLL_RST;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                end
            end
            ST_STABLE: begin
                // A drop restarts the pulse without spending a retry.
                if (!r_locked_s) begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = '0;
                    w_retries_nxt = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                end
            end
            ST_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_loss      = 1'b1;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as r_state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_PLL_RST;
            r_cnt             <= '0;
            r_retries         <= '0;
            r_pll_rst         <= 1'b1;
            r_sys_reset       <= 1'b1;
            r_ready           <= 1'b0;
            r_fail            <= 1'b0;
            r_lock_loss_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retries   <= w_retries_nxt;
            r_pll_rst   <= (w_state_nxt == ST_PLL_RST);
            r_sys_reset <= (w_state_nxt != ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_fail      <= r_fail | (w_state_nxt == ST_FAIL);
            if (w_loss && (r_lock_loss_count != 8'hFF)) begin
                r_lock_loss_count <= r_lock_loss_count + 8'd1;
            end
        end
    end

    assign bus.pll_rst         = r_pll_rst;
    assign bus.sys_reset       = r_sys_reset;
    assign bus.ready           = r_ready;
    assign bus.fail            = r_fail;
    assign bus.lock_loss_count = r_lock_loss_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_seq
// Brief    : Directed self-checking bench for pll_reset_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    localparam int PLL_RST_CYCLES      = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int MAX_RETRIES         = 2;

    logic refclk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pll_reset_seq_if bus ();

    pll_reset_seq #(
        .PLL_RST_CYCLES      (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .MAX_RETRIES         (MAX_RETRIES)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"},   bus.pll_rst,         1);
        check({tag, "_sys_reset"}, bus.sys_reset,       1);
        check({tag, "_ready"},     bus.ready,           0);
        check({tag, "_fail"},      bus.fail,            0);
        check({tag, "_loss_cnt"},  bus.lock_loss_count, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        tick(3);
        check_reset_vals("por");

        // Nominal lock: edges counted from rst_n release.
        rst_n = 1'b1;
        tick(3);
        check("s1_prst_e3", bus.pll_rst, 1);
        tick(1);
        check("s1_prst_e4", bus.pll_rst, 0);
        check("s1_sysrst_e4", bus.sys_reset, 1);
        tick(6);
        bus.pll_locked = 1'b1;
        tick(10);
        check("s1_sysrst_e10", bus.sys_reset, 1);
        check("s1_ready_e10", bus.ready, 0);
        tick(1);
        check("s1_sysrst_e11", bus.sys_reset, 0);
        check("s1_ready_e11", bus.ready, 1);
        check("s1_fail", bus.fail, 0);

        // One-cycle loss while running.
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(1);
        check("s4_sysrst_e2", bus.sys_reset, 0);
        tick(1);
        check("s4_sysrst_e3", bus.sys_reset, 1);
        check("s4_prst_e3", bus.pll_rst, 1);
        check("s4_ready_e3", bus.ready, 0);
        check("s4_loss_cnt", bus.lock_loss_count, 1);
        tick(3);
        check("s4_prst_e6", bus.pll_rst, 1);
        tick(1);
        check("s4_prst_e7", bus.pll_rst, 0);
        tick(8);
        check("s4_sysrst_e15", bus.sys_reset, 1);
        tick(1);
        check("s4_sysrst_e16", bus.sys_reset, 0);
        check("s4_ready_e16", bus.ready, 1);

        // Saturation: 259 further losses.
        for (int i = 2; i <= 260; i++) begin
            bus.pll_locked = 1'b0;
            tick(1);
            bus.pll_locked = 1'b1;
            tick(15);
            check("s5_loss_cnt", bus.lock_loss_count, (i > 255) ? 255 : i);
        end
        check("s5_ready", bus.ready, 1);

        // Asynchronous reset in the middle of STABLE.
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(9);
        check("s6_stable_sysrst", bus.sys_reset, 1);
        check("s6_stable_prst", bus.pll_rst, 0);
        #5 rst_n = 1'b0;
        #1 check_reset_vals("s6_async");
        @(negedge refclk);
        rst_n = 1'b1;
        tick(3);
        check("s6_prst_e3", bus.pll_rst, 1);
        tick(1);
        check("s6_prst_e4", bus.pll_rst, 0);
        tick(8);
        check("s6_sysrst_e12", bus.sys_reset, 1);
        tick(1);
        check("s6_sysrst_e13", bus.sys_reset, 0);
        check("s6_ready_e13", bus.ready, 1);
        check("s6_loss_cnt", bus.lock_loss_count, 0);

        // Unstable lock: high 5, low 3, then high.
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        tick(2);
        check_reset_vals("s2_rst");
        rst_n = 1'b1;
        tick(4);
        check("s2_prst_pre", bus.pll_rst, 0);
        for (int k = 1; k <= 21; k++) begin
            bus.pll_locked = (k >= 6 && k <= 8) ? 1'b0 : 1'b1;
            tick(1);
            if (k <= 20) begin
                check("s2_sysrst", bus.sys_reset, 1);
                check("s2_prst", bus.pll_rst, (k >= 8 && k <= 11) ? 1 : 0);
            end else begin
                check("s2_sysrst_final", bus.sys_reset, 0);
                check("s2_ready_final", bus.ready, 1);
            end
        end

        // Timeout twice, then terminal failure.
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            tick(1);
            check("s3_prst", bus.pll_rst, ((k <= 3) || (k >= 36 && k <= 39)) ? 1 : 0);
            check("s3_fail", bus.fail, (k >= 72) ? 1 : 0);
            check("s3_sysrst", bus.sys_reset, 1);
        end
        bus.pll_locked = 1'b1;
        tick(1000);
        check("s3_hold_fail", bus.fail, 1);
        check("s3_hold_prst", bus.pll_rst, 0);
        check("s3_hold_sysrst", bus.sys_reset, 1);
        check("s3_hold_ready", bus.ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
